router_out_reader: RTL and testbench
====================================

# router_out_reader

Consumer for one router output port. It drains packets from the port's output FIFO by driving `read_enb` against `vld_out`, and checks each packet's header address and parity. It forwards header and payload bytes to a downstream sink through a 2-entry skid buffer with valid/ready flow control. One instance sits behind each of the router's three output ports, so a drained port never reaches the 30-cycle soft-reset timeout through reader inactivity.

## Interface
Parameters:
- PORT_ID, 2'd0, expected value of header[1:0] for packets on this port
- CNT_W, 16, width of packet and error counters

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- vld_out  in  1  router port has data (FIFO not empty)
- data_out  in  8  router FIFO read data, valid 1 cycle after `read_enb`
- soft_reset  in  1  router soft reset for this port (FIFO flushed)
- read_enb  out  1  FIFO read strobe
- sink_ready  in  1  downstream accepts a byte this cycle
- pkt_data  out  8  forwarded byte (header, then payload)
- pkt_valid  out  1  `pkt_data` valid
- pkt_sop  out  1  with `pkt_valid`: byte is the header
- pkt_eop  out  1  with `pkt_valid`: last forwarded byte (header if len=0)
- pkt_done  out  1  1-cycle pulse after the parity byte is captured
- parity_err  out  1  valid with `pkt_done`: computed XOR ≠ parity byte
- addr_err  out  1  valid with `pkt_done`: header[1:0] ≠ PORT_ID
- pkt_abort  out  1  1-cycle pulse when a packet is killed by `soft_reset`
- pkt_cnt  out  CNT_W  completed packets, wraps
- err_cnt  out  CNT_W  packets with parity_err or addr_err, wraps

## Operation
- Packet format:
  - header: [7:2] = payload length L (0..63), [1:0] = address
  - then L payload bytes
  - then 1 parity byte = XOR of header and all payload bytes
- FSM states:
  - IDLE: request the header → HDR.
  - HDR: on header capture, load remaining = L and init XOR = header → PAY if L>0, else PAR.
  - PAY: capture L bytes, XOR each → PAR.
  - PAR: capture the parity byte → DONE.
  - DONE: one cycle; pulse `pkt_done`, update counters → IDLE.
- Request side:
  - `rd_pend` = `read_enb` delayed 1 cycle; a byte is captured from `data_out` whenever `rd_pend`=1.
  - `read_enb` = `vld_out` & (bytes still to request in current packet > 0) & (occ − pop + `rd_pend` ≤ 1).
    - occ = skid entries (0..2).
    - pop = `pkt_valid` & `sink_ready`.
  - The header is requested from IDLE when `vld_out`=1. No new header is requested until DONE is left.
- Skid buffer:
  - 2-entry FIFO of {byte, sop, eop}; `pkt_data`/`pkt_valid` present its head.
  - The parity byte is never pushed into the buffer.
- Flags: `parity_err` and `addr_err` hold their value until the next `pkt_done`.
- Counters:
  - `pkt_cnt` increments in DONE.
  - `err_cnt` increments in DONE if either error flag is set.
  - Both wrap modulo 2^CNT_W.
- `soft_reset`=1 in any non-IDLE state:
  - `read_enb`=0 that cycle.
  - Next cycle: FSM in IDLE, skid buffer emptied, `rd_pend` dropped, 1-cycle `pkt_abort`.
  - Counters unchanged.
  - In IDLE, `soft_reset` only suppresses `read_enb`.

## Timing
- Reset values: all outputs 0, counters 0, FSM IDLE, skid empty, `rd_pend` 0.
- `read_enb` at edge k → byte captured at edge k+1 → `pkt_valid` at earliest after edge k+1.
- Read-to-output latency: 2 cycles.
- Sustained rate: 1 byte/cycle while `vld_out`=1 and `sink_ready`=1.
- `vld_out` low mid-packet: `read_enb` deasserts, state and count hold. There is no timeout inside the reader.
- `sink_ready` low: at most 1 byte in flight plus 2 buffered; bytes are never dropped or reordered.
- `pkt_done` fires the cycle after parity capture, independent of whether the sink has drained the buffer.
- Simultaneous capture and pop: occ unchanged.
- `soft_reset` overrides capture in the same cycle.

## Test plan
- PORT_ID=2, `sink_ready`=1, FIFO holds 0x0E,0x11,0x22,0x33,0x0E → `pkt_data` 0x0E(sop),0x11,0x22,0x33(eop) on 4 consecutive cycles; `pkt_done`=1, both error flags 0, `pkt_cnt`=1.
- Zero length: 0x02,0x02 → single byte 0x02 with sop=eop=1; `pkt_done`, no errors.
- Parity byte 0x0F instead of 0x0E in the first case → `parity_err`=1, `err_cnt`=1, payload still forwarded intact.
- Header 0x0D (addr 1) with PORT_ID=2 and correct parity 0x0D^payload → `addr_err`=1, `parity_err`=0.
- `sink_ready` toggled 1 cycle on, 2 cycles off during the first case → `read_enb` never makes occ exceed 2; output byte sequence identical.
- `soft_reset` pulsed after 2 payload bytes captured → `read_enb`=0 immediately; `pkt_abort` pulse; `pkt_valid`=0 next cycle; `pkt_cnt` unchanged; a following clean packet completes normally.

Source files
------------

// File: rtl/router_out_reader.sv
// Drains one router output FIFO, checks header address and packet parity, and
// forwards header and payload bytes to a sink through a 2-entry skid buffer.
module router_out_reader #(
    parameter logic [1:0] PORT_ID = 2'd0,
    parameter int         CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             vld_out,
    input  logic [7:0]       data_out,
    input  logic             soft_reset,
    output logic             read_enb,
    input  logic             sink_ready,
    output logic [7:0]       pkt_data,
    output logic             pkt_valid,
    output logic             pkt_sop,
    output logic             pkt_eop,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err,
    output logic             pkt_abort,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_PAR, S_DONE} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } entry_t;

    state_t     r_state;
    logic       r_rd_pend;
    logic [6:0] r_req_left;
    logic [5:0] r_remaining;
    logic [7:0] r_xor;
    logic       r_addr_bad;
    logic       r_parity_err;
    logic       r_addr_err;
    logic       r_pkt_done;
    logic       r_pkt_abort;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    entry_t     r_q0;
    entry_t     r_q1;
    logic [1:0] r_occ;

    logic       w_abort;
    logic       w_pop;
    logic       w_cap;
    logic       w_push;
    logic       w_room;
    logic [5:0] w_len;
    logic [6:0] w_req_left;
    entry_t     w_entry;

    assign w_abort = soft_reset && (r_state != S_IDLE);
    assign w_pop   = pkt_valid && sink_ready;
    assign w_cap   = r_rd_pend && !w_abort;
    assign w_len   = data_out[7:2];
    assign w_push  = w_cap && ((r_state == S_HDR) || (r_state == S_PAY));

    assign w_entry.data = data_out;
    assign w_entry.sop  = (r_state == S_HDR);
    assign w_entry.eop  = ((r_state == S_HDR) && (w_len == 6'd0)) ||
                          ((r_state == S_PAY) && (r_remaining == 6'd1));

    // Bytes still to request; the header's length is forwarded the cycle it
    // is captured so the first payload request does not cost a bubble.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_req_left = 7'd0;
        case (r_state)
            S_IDLE:        w_req_left = 7'd1;
            S_HDR:         if (r_rd_pend) w_req_left = {1'b0, w_len} + 7'd1;
            S_PAY, S_PAR:  w_req_left = r_req_left;
            default:       w_req_left = 7'd0;
        endcase
    end

    assign w_room   = ({1'b0, r_occ} + {2'b0, r_rd_pend}) <= (3'd1 + {2'b0, w_pop});
    assign read_enb = vld_out && (w_req_left != 7'd0) && w_room && !soft_reset;

    assign pkt_valid  = (r_occ != 2'd0);
    assign pkt_data   = r_q0.data;
    assign pkt_sop    = pkt_valid && r_q0.sop;
    assign pkt_eop    = pkt_valid && r_q0.eop;
    assign pkt_done   = r_pkt_done;
    assign pkt_abort  = r_pkt_abort;
    assign parity_err = r_parity_err;
    assign addr_err   = r_addr_err;
    assign pkt_cnt    = r_pkt_cnt;
    assign err_cnt    = r_err_cnt;

    // NOTE: the skid entries are reset too, so pkt_data reads 0 out of reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_occ <= 2'd0;
        end else if (w_abort) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_q0 <= w_entry;
                    else               r_q1 <= w_entry;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_q0  <= r_q1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_q0 <= w_entry;
                    end else begin
                        r_q0 <= r_q1;
                        r_q1 <= w_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_rd_pend    <= 1'b0;
            r_req_left   <= 7'd0;
            r_remaining  <= 6'd0;
            r_xor        <= 8'd0;
            r_addr_bad   <= 1'b0;
            r_parity_err <= 1'b0;
            r_addr_err   <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_abort  <= 1'b0;
            r_pkt_cnt    <= '0;
            r_err_cnt    <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only.
            r_pkt_done  <= 1'b0;
            r_pkt_abort <= 1'b0;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_rd_pend   <= 1'b0;
                r_req_left  <= 7'd0;
                r_pkt_abort <= 1'b1;
            end else begin
                r_rd_pend <= read_enb;
                if ((r_state == S_HDR) || (r_state == S_PAY) || (r_state == S_PAR))
                    r_req_left <= w_req_left - {6'd0, read_enb};
                case (r_state)
                    S_IDLE: if (read_enb) r_state <= S_HDR;
                    S_HDR: if (w_cap) begin
                        r_xor       <= data_out;
                        r_remaining <= w_len;
                        r_addr_bad  <= (data_out[1:0] != PORT_ID);
                        r_state     <= (w_len != 6'd0) ? S_PAY : S_PAR;
                    end
                    S_PAY: if (w_cap) begin
                        r_xor       <= r_xor ^ data_out;
                        r_remaining <= r_remaining - 6'd1;
                        if (r_remaining == 6'd1) r_state <= S_PAR;
                    end
                    S_PAR: if (w_cap) begin
                        r_parity_err <= (r_xor != data_out);
                        r_addr_err   <= r_addr_bad;
                        r_pkt_done   <= 1'b1;
                        r_state      <= S_DONE;
                    end
                    S_DONE: begin
                        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                        if (r_parity_err || r_addr_err) r_err_cnt <= r_err_cnt + CNT_W'(1);
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_out_reader.sv
// Directed bench for router_out_reader: a queue models the router FIFO, a
// negedge monitor records every byte the sink accepts.
module tb_router_out_reader;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        vld_out = 1'b0;
    logic [7:0]  data_out = 8'd0;
    logic        soft_reset = 1'b0;
    logic        read_enb;
    logic        sink_ready = 1'b1;
    logic [7:0]  pkt_data;
    logic        pkt_valid, pkt_sop, pkt_eop, pkt_done;
    logic        parity_err, addr_err, pkt_abort;
    logic [15:0] pkt_cnt, err_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sink_mode = 0;

    logic [7:0] fifo_q[$];
    logic [9:0] out_q[$];
    int         out_cyc[$];
    int         done_cnt = 0, abort_cnt = 0;
    logic       last_perr = 1'b0, last_aerr = 1'b0;
    int         reads = 0, pops = 0, dones = 0, max_outst = 0;

    router_out_reader #(.PORT_ID(2'd2), .CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out),
        .soft_reset(soft_reset), .read_enb(read_enb), .sink_ready(sink_ready),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err),
        .pkt_abort(pkt_abort), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // Router FIFO model: a read strobe seen before the edge pops one byte after it.
    initial begin
        logic re;
        forever begin
            @(negedge clock);
            #2 re = read_enb;
            @(posedge clock);
            #1;
            if (re && fifo_q.size() != 0) data_out = fifo_q.pop_front();
            vld_out = (fifo_q.size() != 0);
        end
    end

    initial forever begin
        @(posedge clock);
        #1 sink_ready = (sink_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    initial forever begin
        @(negedge clock);
        if (pkt_done) begin
            done_cnt++; dones++;
            last_perr = parity_err;
            last_aerr = addr_err;
        end
        if (pkt_abort) abort_cnt++;
        if (reads - pops - dones > max_outst) max_outst = reads - pops - dones;
        if (read_enb) reads++;
        if (pkt_valid && sink_ready) begin
            out_q.push_back({pkt_sop, pkt_eop, pkt_data});
            out_cyc.push_back(cyc);
            pops++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string name);
        int start = done_cnt;
        for (int i = 0; i < 300 && done_cnt == start; i++) tick(1);
        total++;
        if (done_cnt == start) begin
            bad++;
            $display("FAIL %s_timeout got=no pkt_done exp=pkt_done within 300 cycles", name);
        end
        tick(12);
    endtask

    task automatic test_reset;
        tick(3);
        total++; if (read_enb !== 1'b0) begin bad++; $display("FAIL reset_read_enb got=%b exp=0", read_enb); end
        total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_pkt_valid got=%b exp=0", pkt_valid); end
        total++; if (pkt_data !== 8'h00) begin bad++; $display("FAIL reset_pkt_data got=%h exp=00", pkt_data); end
        total++; if ({pkt_sop, pkt_eop, pkt_done, pkt_abort} !== 4'b0) begin
            bad++; $display("FAIL reset_pulses got=%b exp=0000", {pkt_sop, pkt_eop, pkt_done, pkt_abort}); end
        total++; if ({parity_err, addr_err} !== 2'b00) begin
            bad++; $display("FAIL reset_flags got=%b exp=00", {parity_err, addr_err}); end
        total++; if (pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", pkt_cnt, err_cnt); end
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic test_basic;
        logic [9:0] exp_b[4] = '{10'h20E, 10'h011, 10'h022, 10'h133};
        out_q.delete(); out_cyc.delete();
        fifo_q.push_back(8'h0E); fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h0E);
        wait_done("basic");
        total++; if (out_q.size() != 4) begin bad++; $display("FAIL basic_len got=%0d exp=4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_b[i]) begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, out_q[i], exp_b[i]); end
        end
        if (out_q.size() == 4) begin
            total++;
            if (out_cyc[3] - out_cyc[0] != 3) begin
                bad++; $display("FAIL basic_rate got=%0d cycles exp=3", out_cyc[3] - out_cyc[0]); end
        end
        total++; if ({last_perr, last_aerr} !== 2'b00) begin
            bad++; $display("FAIL basic_flags got=%b exp=00", {last_perr, last_aerr}); end
        total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL basic_pkt_cnt got=%0d exp=1", pkt_cnt); end
    endtask

    task automatic test_zero_len;
        out_q.delete(); out_cyc.delete();
        fifo_q.push_back(8'h02); fifo_q.push_back(8'h02);
        wait_done("zero");
        total++; if (out_q.size() != 1) begin bad++; $display("FAIL zero_len got=%0d exp=1", out_q.size()); end
        if (out_q.size() != 0) begin
            total++; if (out_q[0] !== 10'h302) begin bad++; $display("FAIL zero_byte got=%h exp=302", out_q[0]); end
        end
        total++; if ({last_perr, last_aerr} !== 2'b00) begin
            bad++; $display("FAIL zero_flags got=%b exp=00", {last_perr, last_aerr}); end
        total++; if (pkt_cnt !== 16'd2 || err_cnt !== 16'd0) begin
            bad++; $display("FAIL zero_counters got=%0d/%0d exp=2/0", pkt_cnt, err_cnt); end
    endtask

    task automatic test_parity_err;
        logic [9:0] exp_b[4] = '{10'h20E, 10'h011, 10'h022, 10'h133};
        out_q.delete(); out_cyc.delete();
        fifo_q.push_back(8'h0E); fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h0F);
        wait_done("parity");
        total++; if (out_q.size() != 4) begin bad++; $display("FAIL parity_len got=%0d exp=4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_b[i]) begin bad++; $display("FAIL parity_byte%0d got=%h exp=%h", i, out_q[i], exp_b[i]); end
        end
        total++; if ({last_perr, last_aerr} !== 2'b10) begin
            bad++; $display("FAIL parity_flags got=%b exp=10", {last_perr, last_aerr}); end
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL parity_hold got=%b exp=1", parity_err); end
        total++; if (pkt_cnt !== 16'd3 || err_cnt !== 16'd1) begin
            bad++; $display("FAIL parity_counters got=%0d/%0d exp=3/1", pkt_cnt, err_cnt); end
    endtask

    task automatic test_addr_err;
        // 0x0D ^ 0x11 ^ 0x22 ^ 0x33 = 0x0D
        out_q.delete(); out_cyc.delete();
        fifo_q.push_back(8'h0D); fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h0D);
        wait_done("addr");
        total++; if (out_q.size() != 4 || out_q[0] !== 10'h20D) begin
            bad++; $display("FAIL addr_stream got=%0d bytes exp=4 starting 20D", out_q.size()); end
        total++; if ({last_perr, last_aerr} !== 2'b01) begin
            bad++; $display("FAIL addr_flags got=%b exp=01", {last_perr, last_aerr}); end
        total++; if (pkt_cnt !== 16'd4 || err_cnt !== 16'd2) begin
            bad++; $display("FAIL addr_counters got=%0d/%0d exp=4/2", pkt_cnt, err_cnt); end
    endtask

    task automatic test_backpressure;
        logic [9:0] exp_b[4] = '{10'h20E, 10'h011, 10'h022, 10'h133};
        out_q.delete(); out_cyc.delete();
        reads = 0; pops = 0; dones = 0; max_outst = 0;
        sink_mode = 1;
        fifo_q.push_back(8'h0E); fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h0E);
        wait_done("bp");
        tick(12);
        sink_mode = 0;
        tick(2);
        total++; if (out_q.size() != 4) begin bad++; $display("FAIL bp_len got=%0d exp=4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_b[i]) begin bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, out_q[i], exp_b[i]); end
        end
        total++; if (max_outst > 3) begin bad++; $display("FAIL bp_outstanding got=%0d exp<=3", max_outst); end
        total++; if (pkt_cnt !== 16'd5 || last_perr !== 1'b0) begin
            bad++; $display("FAIL bp_done got=%0d/%b exp=5/0", pkt_cnt, last_perr); end
    endtask

    task automatic test_soft_reset;
        logic found = 1'b0;
        out_q.delete(); out_cyc.delete();
        fifo_q.push_back(8'h0E); fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h0E);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (pkt_valid && pkt_data == 8'h11) begin found = 1'b1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL sr_wait got=no 0x11 exp=0x11 within 100 cycles"); end
        @(negedge clock);
        total++; if (pkt_data !== 8'h22) begin bad++; $display("FAIL sr_head got=%h exp=22", pkt_data); end
        soft_reset = 1'b1;
        fifo_q.delete();
        #1;
        total++; if (read_enb !== 1'b0) begin bad++; $display("FAIL sr_read_enb got=%b exp=0", read_enb); end
        @(posedge clock);
        #1 soft_reset = 1'b0;
        @(negedge clock);
        total++; if (pkt_abort !== 1'b1 || pkt_valid !== 1'b0) begin
            bad++; $display("FAIL sr_abort got=%b/%b exp=1/0", pkt_abort, pkt_valid); end
        @(negedge clock);
        total++; if (pkt_abort !== 1'b0) begin bad++; $display("FAIL sr_abort_pulse got=%b exp=0", pkt_abort); end
        total++; if (out_q.size() != 3 || pkt_cnt !== 16'd5) begin
            bad++; $display("FAIL sr_state got=%0d bytes cnt=%0d exp=3 bytes cnt=5", out_q.size(), pkt_cnt); end
        tick(2);
        out_q.delete(); out_cyc.delete();
        fifo_q.push_back(8'h06); fifo_q.push_back(8'hAA); fifo_q.push_back(8'hAC);
        wait_done("sr_clean");
        total++; if (out_q.size() != 2 || out_q[0] !== 10'h206 || out_q[out_q.size()-1] !== 10'h1AA) begin
            bad++; $display("FAIL sr_clean_stream got=%0d bytes exp=206,1AA", out_q.size()); end
        total++; if (pkt_cnt !== 16'd6 || err_cnt !== 16'd2 || {last_perr, last_aerr} !== 2'b00) begin
            bad++; $display("FAIL sr_clean_done got=%0d/%0d/%b exp=6/2/00", pkt_cnt, err_cnt, {last_perr, last_aerr}); end
        total++; if (abort_cnt != 1) begin bad++; $display("FAIL sr_abort_count got=%0d exp=1", abort_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_parity_err();
        test_addr_err();
        test_backpressure();
        test_soft_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
